// File: rtl/core_pkg.sv
// Shared core definitions: hazard controller state encoding, register
// specifier width and the EX-slot record reused by the pipeline latches.
package core_pkg;

  localparam int CORE_REGW = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MULBUSY = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                 v;
    logic [CORE_REGW-1:0] rd;
    logic                 load;
    logic                 wr;
  } ex_slot_t;

endpackage

// File: rtl/hazard_cmp.sv
// Operand match of the decode rn/rm specifiers against the EX destination,
// qualified by whether each operand is actually read.
module hazard_cmp #(
  parameter int REGW = 4
) (
  input  logic [REGW-1:0] ex_rd,
  input  logic [REGW-1:0] id_rn,
  input  logic [REGW-1:0] id_rm,
  input  logic            use_rn,
  input  logic            use_rm,
  output logic            match
);

  assign match = (use_rn && (id_rn == ex_rd)) || (use_rm && (id_rm == ex_rd));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID/EX hazard controller: load-use interlock, multi-cycle multiply occupancy
// and taken-branch squash, plus a saturating hazard statistics counter.
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int REGW       = CORE_REGW,
  parameter int MUL_CYCLES = 4,
  parameter int CNTW       = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rd,
  input  logic [REGW-1:0] id_rn,
  input  logic [REGW-1:0] id_rm,
  input  logic            id_uses_rn,
  input  logic            id_uses_rm,
  input  logic            id_writes_rd,
  input  logic            id_is_load,
  input  logic            id_is_mul,
  input  logic            ex_br_taken,
  output logic            stall_if,
  output logic            stall_id,
  output logic            bubble_ex,
  output logic            flush_if,
  output logic            ex_busy,
  output logic [CNTW-1:0] hazard_cnt
);

  localparam int MCW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  hz_state_e       state_r, state_nx;
  ex_slot_t        ex_r;
  logic [MCW-1:0]  mul_cnt_r;
  logic            rd_match_s;
  logic            load_use_s;
  logic            advance_s;

  hazard_cmp #(.REGW(REGW)) u_cmp (
    .ex_rd  (ex_r.rd),
    .id_rn  (id_rn),
    .id_rm  (id_rm),
    .use_rn (id_uses_rn),
    .use_rm (id_uses_rm),
    .match  (rd_match_s)
  );

  assign load_use_s = ex_r.v && ex_r.load && ex_r.wr && id_valid && rd_match_s;

  // Control outputs and next state, in priority order branch > mul > load-use.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    ex_busy   = 1'b0;
    advance_s = 1'b0;
    state_nx  = ST_RUN;
    if (ex_br_taken) begin
      flush_if  = 1'b1;
      bubble_ex = 1'b1;
      state_nx  = ST_RUN;
    end else if (state_r == ST_MULBUSY) begin
      ex_busy  = 1'b1;
      stall_if = 1'b1;
      stall_id = 1'b1;
      state_nx = (mul_cnt_r <= MCW'(1)) ? ST_RUN : ST_MULBUSY;
    end else if ((state_r == ST_RUN) && load_use_s) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
      state_nx  = ST_LDSTALL;
    end else begin
      // Only a multiply issued from RUN claims EX for the extra cycles.
      advance_s = 1'b1;
      state_nx  = ((state_r == ST_RUN) && id_valid && id_is_mul) ? ST_MULBUSY : ST_RUN;
    end
  end

  // State, EX slot, multiply countdown and hazard statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_RUN;
      ex_r       <= '0;
      mul_cnt_r  <= '0;
      hazard_cnt <= '0;
    end else begin
      state_r <= state_nx;
      if (advance_s) begin
        ex_r.v    <= id_valid;
        ex_r.rd   <= id_rd;
        ex_r.load <= id_is_load;
        ex_r.wr   <= id_writes_rd;
      end else begin
        ex_r.v <= 1'b0;
      end
      if (advance_s && (state_nx == ST_MULBUSY)) begin
        mul_cnt_r <= MCW'(MUL_CYCLES - 1);
      end else if ((state_r == ST_MULBUSY) && !ex_br_taken) begin
        mul_cnt_r <= mul_cnt_r - MCW'(1);
      end else begin
        mul_cnt_r <= '0;
      end
      if ((stall_id || flush_if) && (hazard_cnt != {CNTW{1'b1}})) begin
        hazard_cnt <= hazard_cnt + CNTW'(1);
      end else begin
        hazard_cnt <= hazard_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int REGW       = 4;
  localparam int MUL_CYCLES = 4;
  localparam int CNTW       = 4;
  localparam int CNT_MAX    = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            id_valid, id_uses_rn, id_uses_rm, id_writes_rd, id_is_load, id_is_mul;
  logic [REGW-1:0] id_rd, id_rn, id_rm;
  logic            ex_br_taken = 1'b0;
  logic            stall_if, stall_id, bubble_ex, flush_if, ex_busy;
  logic [CNTW-1:0] hazard_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REGW(REGW), .MUL_CYCLES(MUL_CYCLES), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd), .id_rn(id_rn),
    .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .id_writes_rd(id_writes_rd), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .ex_br_taken(ex_br_taken), .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .flush_if(flush_if), .ex_busy(ex_busy), .hazard_cnt(hazard_cnt)
  );

  // Behavioural model: remaining mul stall cycles, pending load-use issue,
  // the instruction in EX and the hazard count.
  int              m_busy = 0;
  bit              m_after_ld = 1'b0;
  bit              m_ex_v = 1'b0, m_ex_ld = 1'b0, m_ex_wr = 1'b0;
  logic [REGW-1:0] m_ex_rd = '0;
  int              m_cnt = 0;
  bit              m_live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {stall_if, stall_id, bubble_ex, flush_if, ex_busy}
  function automatic logic [4:0] model_out();
    bit dep;
    dep = m_ex_v && m_ex_ld && m_ex_wr && id_valid &&
          ((id_uses_rn && id_rn == m_ex_rd) || (id_uses_rm && id_rm == m_ex_rd));
    if (ex_br_taken)            return 5'b00110;
    if (m_busy > 0)             return 5'b11001;
    if (!m_after_ld && dep)     return 5'b11100;
    return 5'b00000;
  endfunction

  initial forever begin
    logic [4:0] e;
    bit         from_run;
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_after_ld = 1'b0; m_ex_v = 1'b0; m_cnt = 0; m_live = 1'b1;
    end else if (m_live) begin
      e = model_out();
      if ((e[3] || e[1]) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (ex_br_taken) begin
        m_busy = 0; m_after_ld = 1'b0; m_ex_v = 1'b0;
      end else if (m_busy > 0) begin
        m_busy = m_busy - 1; m_ex_v = 1'b0;
      end else if (e[3]) begin
        m_after_ld = 1'b1; m_ex_v = 1'b0;
      end else begin
        from_run   = !m_after_ld;
        m_after_ld = 1'b0;
        m_ex_v = id_valid; m_ex_rd = id_rd; m_ex_ld = id_is_load; m_ex_wr = id_writes_rd;
        if (from_run && id_valid && id_is_mul) m_busy = MUL_CYCLES - 1;
      end
    end
  end

  initial forever begin
    logic [4:0] e;
    @(negedge clk);
    if (m_live) begin
      e = model_out();
      check("m_stall_if",  32'(stall_if),   32'(e[4]));
      check("m_stall_id",  32'(stall_id),   32'(e[3]));
      check("m_bubble_ex", 32'(bubble_ex),  32'(e[2]));
      check("m_flush_if",  32'(flush_if),   32'(e[1]));
      check("m_ex_busy",   32'(ex_busy),    32'(e[0]));
      check("m_hazard_cnt", 32'(hazard_cnt), 32'(m_cnt));
    end
  end

  task automatic set_id(input bit v, input logic [REGW-1:0] rd, rn, rm,
                        input bit urn, urm, wr, ld, mul);
    id_valid = v; id_rd = rd; id_rn = rn; id_rm = rm; id_uses_rn = urn;
    id_uses_rm = urm; id_writes_rd = wr; id_is_load = ld; id_is_mul = mul;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ldr_r3();
    set_id(1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic mul_r8();
    set_id(1'b1, 4'd8, 4'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    nop();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_stall_id", 32'(stall_id), 32'd0);
    check("rst_flush_if", 32'(flush_if), 32'd0);
    check("rst_ex_busy", 32'(ex_busy), 32'd0);
    check("rst_cnt", 32'(hazard_cnt), 32'd0);

    // Load r3 then dependent ADD: exactly one interlock cycle.
    cyc(); ldr_r3();
    cyc(); set_id(1'b1, 4'd6, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_stall_id", 32'(stall_id), 32'd1);
    check("lu_stall_if", 32'(stall_if), 32'd1);
    check("lu_bubble", 32'(bubble_ex), 32'd1);
    cyc(); @(negedge clk);
    check("lu_issue_stall", 32'(stall_id), 32'd0);
    check("lu_cnt", 32'(hazard_cnt), 32'd1);

    // No-match and unused-operand cases.
    cyc(); ldr_r3();
    cyc(); set_id(1'b1, 4'd6, 4'd4, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("nomatch_stall", 32'(stall_id), 32'd0);
    cyc(); ldr_r3();
    cyc(); set_id(1'b1, 4'd6, 4'd3, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("unused_rn_stall", 32'(stall_id), 32'd0);

    // Multiply occupies EX for three extra cycles.
    cyc(); mul_r8();
    @(negedge clk);
    check("mul_issue_busy", 32'(ex_busy), 32'd0);
    cyc(); nop();
    for (int i = 0; i < MUL_CYCLES - 1; i++) begin
      @(negedge clk);
      check("mul_busy", 32'(ex_busy), 32'd1);
      check("mul_stall", 32'(stall_id), 32'd1);
      cyc();
    end
    @(negedge clk);
    check("mul_done_busy", 32'(ex_busy), 32'd0);
    check("mul_done_stall", 32'(stall_id), 32'd0);
    check("mul_cnt", 32'(hazard_cnt), 32'd4);

    // Taken branch wins over a live load-use condition.
    cyc(); ldr_r3();
    cyc(); set_id(1'b1, 4'd6, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); ex_br_taken = 1'b1;
    @(negedge clk);
    check("br_flush", 32'(flush_if), 32'd1);
    check("br_bubble", 32'(bubble_ex), 32'd1);
    check("br_stall_id", 32'(stall_id), 32'd0);
    check("br_stall_if", 32'(stall_if), 32'd0);
    cyc(); ex_br_taken = 1'b0;
    @(negedge clk);
    check("br_after_stall", 32'(stall_id), 32'd0);
    check("br_cnt", 32'(hazard_cnt), 32'd5);

    // Reset while the multiply countdown is at 2.
    cyc(); mul_r8();
    cyc(); nop();
    cyc();
    @(negedge clk);
    check("rst_mul_busy_pre", 32'(ex_busy), 32'd1);
    reset = 1'b1;
    cyc(); reset = 1'b0;
    @(negedge clk);
    check("rst_mul_busy", 32'(ex_busy), 32'd0);
    check("rst_mul_stall", 32'(stall_id), 32'd0);
    check("rst_mul_bubble", 32'(bubble_ex), 32'd0);
    check("rst_mul_cnt", 32'(hazard_cnt), 32'd0);

    // Back-to-back multiplies push the 4-bit counter into saturation.
    cyc(); mul_r8();
    repeat (30) cyc();
    nop();
    @(negedge clk);
    check("sat_cnt", 32'(hazard_cnt), 32'd15);

    // Randomized traffic against the model.
    repeat (600) begin
      cyc();
      reset       = ($urandom_range(0, 59) == 0);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      set_id(($urandom_range(0, 4) != 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end
    cyc(); reset = 1'b0; ex_br_taken = 1'b0; nop();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
